i2c_target: RTL

//  I2C target (responder) on the same SCL/SDA bus that the master drives. Sits beside
//  the master in top, so the whole bus runs inside the team's benches.
//  - Decodes START, STOP and repeated START.
//  - Matches a 7-bit address and ACKs it.
//  - Writes: first data byte sets a register pointer; later bytes write through a port.
//  - Reads: returns bytes via a combinational read port; pointer auto-increments.

---
 rtl/i2c_pkg.sv | 17 +
 rtl/i2c_sync_edge.sv | 31 +++
 rtl/i2c_target.sv | 209 ++++++++++++++++++++
 3 files changed

// File: rtl/i2c_pkg.sv
// Shared definitions for the I2C target: FSM state encoding and R/W bit meaning.
package i2c_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ADDR  = 3'd1,
        ACK_A = 3'd2,
        RX    = 3'd3,
        ACK_R = 3'd4,
        TX    = 3'd5,
        ACK_T = 3'd6
    } i2c_state_e;

    localparam logic I2C_RW_WRITE = 1'b0;
    localparam logic I2C_RW_READ  = 1'b1;

endpackage

// File: rtl/i2c_sync_edge.sv
// Two-flop synchronizer for an asynchronous bus line plus a one-flop edge detector.
// Idle level is high (pull-up), so flops reset to 1 to avoid a spurious edge.
module i2c_sync_edge #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic async_i,
    output logic level_o,
    output logic rise_o,
    output logic fall_o
);

    logic [1:0] sync_q;
    logic       prev_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= {2{RESET_VAL}};
            prev_q <= RESET_VAL;
        end else begin
            sync_q <= {sync_q[0], async_i};
            prev_q <= sync_q[1];
        end
    end

    assign level_o = sync_q[1];
    assign rise_o  = sync_q[1] & ~prev_q;
    assign fall_o  = ~sync_q[1] & prev_q;

endmodule

// File: rtl/i2c_target.sv
// I2C target: START/STOP decode, 7-bit address match, pointer-byte register writes
// and auto-incrementing reads through a combinational register read port.
module i2c_target
    import i2c_pkg::*;
#(
    parameter logic [6:0] TARGET_ADDR = 7'h3C,
    parameter int         PTR_W       = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             scl_i,
    input  logic             sda_i,
    output logic             sda_oe,
    output logic             wr_en,
    output logic [PTR_W-1:0] wr_addr,
    output logic [7:0]       wr_data,
    output logic [PTR_W-1:0] rd_addr,
    input  logic [7:0]       rd_data,
    output logic             busy
);

    localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);

    logic scl_lvl, scl_rise, scl_fall;
    logic sda_lvl, sda_rise, sda_fall;
    logic start_det, stop_det;

    i2c_sync_edge u_scl_sync (
        .clk    (clk),
        .rst_n  (rst_n),
        .async_i(scl_i),
        .level_o(scl_lvl),
        .rise_o (scl_rise),
        .fall_o (scl_fall)
    );

    i2c_sync_edge u_sda_sync (
        .clk    (clk),
        .rst_n  (rst_n),
        .async_i(sda_i),
        .level_o(sda_lvl),
        .rise_o (sda_rise),
        .fall_o (sda_fall)
    );

    assign start_det = sda_fall & scl_lvl;
    assign stop_det  = sda_rise & scl_lvl;

    i2c_state_e       state_q, state_d;
    logic [7:0]       shift_q, shift_d;
    logic [3:0]       bit_cnt_q, bit_cnt_d;
    logic [PTR_W-1:0] ptr_q, ptr_d;
    logic             first_q, first_d;
    logic             rw_q, rw_d;
    logic             oe_q, oe_d;
    logic             busy_q, busy_d;
    logic             wr_en_q, wr_en_d;
    logic [PTR_W-1:0] wr_addr_q, wr_addr_d;
    logic [7:0]       wr_data_q, wr_data_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            shift_q   <= '0;
            bit_cnt_q <= '0;
            ptr_q     <= '0;
            first_q   <= 1'b0;
            rw_q      <= I2C_RW_WRITE;
            oe_q      <= 1'b0;
            busy_q    <= 1'b0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
        end else begin
            state_q   <= state_d;
            shift_q   <= shift_d;
            bit_cnt_q <= bit_cnt_d;
            ptr_q     <= ptr_d;
            first_q   <= first_d;
            rw_q      <= rw_d;
            oe_q      <= oe_d;
            busy_q    <= busy_d;
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        bit_cnt_d = bit_cnt_q;
        ptr_d     = ptr_q;
        first_d   = first_q;
        rw_d      = rw_q;
        oe_d      = oe_q;
        busy_d    = busy_q;
        wr_en_d   = 1'b0;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;

        if (start_det) begin
            state_d   = ADDR;
            bit_cnt_d = '0;
            oe_d      = 1'b0;
        end else if (stop_det) begin
            state_d = IDLE;
            busy_d  = 1'b0;
            oe_d    = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                end
                ADDR, RX: begin
                    if (scl_rise) begin
                        shift_d   = {shift_q[6:0], sda_lvl};
                        bit_cnt_d = bit_cnt_q + 4'd1;
                    end else if (scl_fall && bit_cnt_q == 4'd8) begin
                        bit_cnt_d = '0;
                        if (state_q == RX) begin
                            state_d = ACK_R;
                            oe_d    = 1'b1;
                            // The first byte after the address only moves the pointer.
                            if (first_q) begin
                                ptr_d   = shift_q[PTR_W-1:0];
                                first_d = 1'b0;
                            end else begin
                                wr_en_d   = 1'b1;
                                wr_addr_d = ptr_q;
                                wr_data_d = shift_q;
                                ptr_d     = ptr_q + PTR_ONE;
                            end
                        end else if (shift_q[7:1] == TARGET_ADDR) begin
                            state_d = ACK_A;
                            oe_d    = 1'b1;
                            busy_d  = 1'b1;
                            rw_d    = shift_q[0];
                        end else begin
                            state_d = IDLE;
                            oe_d    = 1'b0;
                            busy_d  = 1'b0;
                        end
                    end
                end
                ACK_A: begin
                    if (scl_fall) begin
                        bit_cnt_d = '0;
                        if (rw_q == I2C_RW_READ) begin
                            state_d = TX;
                            shift_d = rd_data;
                            oe_d    = ~rd_data[7];
                        end else begin
                            state_d = RX;
                            oe_d    = 1'b0;
                            first_d = 1'b1;
                        end
                    end
                end
                ACK_R: begin
                    if (scl_fall) begin
                        state_d = RX;
                        oe_d    = 1'b0;
                    end
                end
                TX: begin
                    if (scl_rise) begin
                        bit_cnt_d = bit_cnt_q + 4'd1;
                    end else if (scl_fall) begin
                        if (bit_cnt_q == 4'd8) begin
                            state_d   = ACK_T;
                            bit_cnt_d = '0;
                            oe_d      = 1'b0;
                            ptr_d     = ptr_q + PTR_ONE;
                        end else begin
                            shift_d = {shift_q[6:0], 1'b0};
                            oe_d    = ~shift_q[6];
                        end
                    end
                end
                ACK_T: begin
                    // bit_cnt=1 marks "master ACKed"; the next byte starts on the following fall.
                    if (scl_rise) begin
                        if (sda_lvl) begin
                            state_d = IDLE;
                            busy_d  = 1'b0;
                            oe_d    = 1'b0;
                        end else begin
                            bit_cnt_d = 4'd1;
                        end
                    end else if (scl_fall && bit_cnt_q == 4'd1) begin
                        state_d   = TX;
                        bit_cnt_d = '0;
                        shift_d   = rd_data;
                        oe_d      = ~rd_data[7];
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    assign sda_oe  = oe_q;
    assign wr_en   = wr_en_q;
    assign wr_addr = wr_addr_q;
    assign wr_data = wr_data_q;
    assign rd_addr = ptr_q;
    assign busy    = busy_q;

endmodule
